// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: two writeback request ports plus the register-file write port
interface rf_write_arbiter_if #(parameter int DATA_W = 64);
   logic              req0_valid;
   logic [4:0]        req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [4:0]        req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              wr_en;
   logic [4:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [31:0]       pending;
   modport master (
      output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, pending
   );
   modport slave (
      input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready, wr_en, wr_addr, wr_data, pending
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates ALU and load writebacks onto the single register-file write port
module rf_write_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ZERO_REG = 31
) (
   input logic               clk,
   input logic               reset_n,
   rf_write_arbiter_if.slave bus
);
   logic              hv0, hv1, rr_last, old1;
   logic [4:0]        ha0, ha1;
   logic [DATA_W-1:0] hd0, hd1;
   logic              g0, g1, ld0, ld1;
   // old1 marks port 1 as the older entry; only consulted when both hold the same register
   always_comb begin
      g1 = hv1 && (!hv0 || ((ha0 == ha1) ? old1 : !rr_last));
      g0 = hv0 && !g1;
      bus.req0_ready = !hv0 || g0;
      bus.req1_ready = !hv1 || g1;
      ld0 = bus.req0_valid && bus.req0_ready && (bus.req0_addr != 5'(ZERO_REG));
      ld1 = bus.req1_valid && bus.req1_ready && (bus.req1_addr != 5'(ZERO_REG));
      bus.wr_en   = g0 || g1;
      bus.wr_addr = g0 ? ha0 : g1 ? ha1 : '0;
      bus.wr_data = g0 ? hd0 : g1 ? hd1 : '0;
      bus.pending = (32'(hv0) << ha0) | (32'(hv1) << ha1);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hv0     <= 1'b0;
         hv1     <= 1'b0;
         ha0     <= '0;
         ha1     <= '0;
         hd0     <= '0;
         hd1     <= '0;
         rr_last <= 1'b1;
         old1    <= 1'b0;
      end else begin
         if (ld0) begin
            hv0 <= 1'b1;
            ha0 <= bus.req0_addr;
            hd0 <= bus.req0_data;
         end else if (g0) hv0 <= 1'b0;
         if (ld1) begin
            hv1 <= 1'b1;
            ha1 <= bus.req1_addr;
            hd1 <= bus.req1_data;
         end else if (g1) hv1 <= 1'b0;
         if (g0 || g1) rr_last <= g1;
         // a fresh port-0 load is never older; a lone port-1 load is younger than a held port 0
         if (ld0) old1 <= 1'b1;
         else if (ld1) old1 <= 1'b0;
      end
   end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port arbiter for the 32×64 register file. It accepts writeback requests from two producers, the ALU path (port 0) and the memory-load path (port 1), each through a valid/ready handshake. It holds at most one request per port and grants the single register-file write port to one request per cycle. Its wr_addr/wr_en outputs drive the 5:32 write-select decoder directly, and its pending mask lets the hazard unit stall reads of registers that still have an outstanding write.

## Interface
- DATA_W, 64, write-data width
- ZERO_REG, 31, register index that is hard-wired zero; writes to it are discarded
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  ALU writeback request
- req0_addr  in  5  destination register
- req0_data  in  DATA_W  write data
- req0_ready  out  1  port 0 can accept this cycle
- req1_valid  in  1  memory-load writeback request
- req1_addr  in  5  destination register
- req1_data  in  DATA_W  write data
- req1_ready  out  1  port 1 can accept this cycle
- wr_en  out  1  register-file write enable (decoder en)
- wr_addr  out  5  register-file write address (decoder in)
- wr_data  out  DATA_W  register-file write data
- pending  out  32  bit r set while an accepted, unwritten write to register r is held

## Operation
- **Per-port holding register:** each port i has one holding register (hv_i, ha_i, hd_i).
- **Acceptance:** occurs on a clock edge with reqi_valid && reqi_ready.
- **Ready:** reqi_ready = !hv_i || grant_i. It depends on state only, with no combinational path from any valid input.
- **Zero-register requests:** an accepted request with addr == ZERO_REG completes its handshake but loads nothing, is never written, and never sets pending.
- **Grant selection, one port only:**
  - One holding register valid: grant it.
  - Both valid and ha_0 != ha_1: round-robin, granting the port not granted last (rr_last). rr_last updates on every grant.
  - Both valid and ha_0 == ha_1: grant the older entry; rr_last is still updated. This preserves write order to the same register.
- **Age:**
  - An entry accepted while the other port holds an entry that is not being granted that cycle is the younger of the two.
  - When both ports are accepted in the same cycle, port 1 is older.
- **Write outputs:** wr_en = grant_0 || grant_1. wr_addr and wr_data come from the granted holding register and are 0 when wr_en = 0.
- **Register-file update:** the register file writes at the edge that ends the grant cycle. The granted holding register clears at that same edge unless it is reloaded by a new acceptance.
- **Pending mask:** pending = onehot(ha_0) & hv_0 | onehot(ha_1) & hv_1. It is combinational from state.
- **Reset values:**
  - hv_0 = hv_1 = 0; ha and hd = 0.
  - rr_last = 1, so port 0 wins the first round-robin contest.
  - Outputs: wr_en = 0, wr_addr = 0, wr_data = 0, pending = 0, req0_ready = req1_ready = 1.
- **Reset asserted mid-operation:** all held entries are discarded immediately and no write is issued for them. Outputs return to their reset values asynchronously.

## Timing
- **Latency:** a request accepted at edge N is written at edge N+1 at the earliest, with wr_en high during cycle N+1. If it loses arbitration, it waits in its holding register.
- **Throughput:**
  - One register-file write per cycle.
  - A single port streaming alone sustains 1 request per cycle: grant and reload happen at the same edge.
  - Two ports streaming together get 1 per cycle combined, alternating ports.
- **Starvation bound:** a held entry is written within 2 cycles of acceptance.
- **Simultaneous accept and grant on one port:** the old entry is written and the new entry loads at the same edge. Pending stays set if the new address equals the old one.
- **Ready while full:** a port whose holding register is full and not granted has ready = 0. The producer must keep valid, addr and data stable until acceptance.
- **Ordering rule:** the arbiter makes no ordering guarantee across different registers. For the same register, writes are applied in acceptance order, with a same-cycle tie resolved as port 1 first.

## Test plan
- **Reset, then single write:** release reset_n, idle → both readys = 1, wr_en = 0, pending = 0. Send req0 with addr 5, data 0xA5 at edge 1 → in cycle 2, wr_en = 1, wr_addr = 5, wr_data = 0xA5, pending[5] = 1. After edge 2, pending = 0.
- **Contest on different registers:** both ports valid at edge 1, addr 3 on port 0 and addr 7 on port 1 → cycle 2 writes 3 (rr_last reset to 1); cycle 3 writes 7. In cycle 2, req1_ready = 0 and req0_ready = 1.
- **Same-register ordering:** both ports accepted at edge 1, both addr 9, port 0 data 0x11 and port 1 data 0x22 → port 1 written in cycle 2, then port 0 in cycle 3, so the final content is 0x11. pending[9] stays 1 through cycle 3.
- **Zero register:** req1 with addr 31, data 0xFF accepted → wr_en stays 0 and pending[31] never sets. Port 1 accepts again on the next edge.
- **Streaming:** req0 valid every cycle for 8 cycles, addr 0..7 → 8 consecutive write cycles, and req0_ready stays 1 throughout. Then run both ports streaming → grants alternate 0,1,0,1.
- **Reset mid-operation:** both holding registers full, then assert reset_n low between edges → wr_en, wr_addr, pending and hv go to 0 immediately. After release, no stale write appears.
